// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//
// Shared constants and types for the multiplexed 7-segment scanner.
//
// Contents:
//   NIBBLE_W          width of one hex digit code
//   MAX_DIGITS        largest supported digit count
//   AN_OFF            all-ones anode pattern (every digit dark); slice to width
//   scan_state_t      per-slot display state {BLANK, DRIVE}
//   *_DEF             default parameter values for seg7_scan
//   idx_width()       width of the digit index (never less than 1)
//
// Related configuration macro: SEG7_SCAN_LZB_EN (leading-zero blanking),
// consumed by seg7_scan.
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 8;

    // Common-anode display: a high anode enable turns the digit off.
    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam int DIGITS_DEF       = 4;
    localparam int REFRESH_DIV_DEF  = 50000;
    localparam int BLANK_CYCLES_DEF = 16;

    // A single-digit display still carries a one-bit index so the port exists.
    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// -----------------------------------------------------------------------------
// seg7_scan_timer
//
// Slot timebase for the display scanner. A counter runs 0..REFRESH_DIV-1 within
// each digit slot; on wrap the digit index advances and wraps after the last
// digit.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   cnt        out  position inside the current slot (registered)
//   digit_idx  out  current slot / digit index (registered)
//   slot_wrap  out  high on the last cycle of every slot (decoded from cnt)
//   frame_end  out  high on the last cycle of the last slot (frame boundary)
// -----------------------------------------------------------------------------
module seg7_scan_timer
    import seg7_pkg::*;
#(
    parameter  int DIGITS      = DIGITS_DEF,
    parameter  int REFRESH_DIV = REFRESH_DIV_DEF,
    localparam int CNT_W       = $clog2(REFRESH_DIV),
    localparam int IDX_W       = idx_width(DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cnt,
    output logic [IDX_W-1:0] digit_idx,
    output logic             slot_wrap,
    output logic             frame_end
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    assign slot_wrap = (cnt == CNT_MAX);
    assign frame_end = slot_wrap && (digit_idx == IDX_MAX);

    // NOTE: clocked state uses non-blocking assignments so every register in
    // the design samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            digit_idx <= '0;
        end else if (slot_wrap) begin
            cnt       <= '0;
            // With DIGITS == 1 IDX_MAX is 0, so the index is pinned at 0.
            digit_idx <= (digit_idx == IDX_MAX) ? '0 : digit_idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan
//
// Multiplexed scanner for an N-digit common-anode 7-segment display. A packed
// hex value is captured on `load` into a shadow register and transferred to the
// displayed (`active`) register only at a frame boundary, so a frame never
// shows a mix of old and new digits. Each digit slot starts with BLANK_CYCLES of
// all-anodes-off to suppress ghosting while the segment code settles.
//
// Parameters:
//   DIGITS        1..8 digits
//   REFRESH_DIV   clock cycles per digit slot (>= 2)
//   BLANK_CYCLES  blanked cycles at slot start (1 .. REFRESH_DIV-1)
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   value_in    in   packed value, digit k = value_in[4k+3:4k]
//   load        in   one-cycle capture strobe
//   nibble      out  code of the current digit, to the segment decoder
//   an_n        out  active-low anode enables, at most one low
//   digit_idx   out  current slot index
//   frame_done  out  one-cycle pulse on the last cycle of each frame
//
// Configuration macro:
//   SEG7_SCAN_LZB_EN  leading-zero blanking: digits above the highest non-zero
//                     digit of the displayed value stay dark; digit 0 always
//                     shows. Undefined: every digit is driven.
//
// All outputs come straight from registers. The register updates are computed
// one cycle ahead so each output lines up with the slot counter value it
// belongs to.
// -----------------------------------------------------------------------------
module seg7_scan
    import seg7_pkg::*;
#(
    parameter  int DIGITS       = DIGITS_DEF,
    parameter  int REFRESH_DIV  = REFRESH_DIV_DEF,
    parameter  int BLANK_CYCLES = BLANK_CYCLES_DEF,
    localparam int IDX_W        = idx_width(DIGITS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NIBBLE_W*DIGITS-1:0] value_in,
    input  logic                       load,
    output logic [NIBBLE_W-1:0]        nibble,
    output logic [DIGITS-1:0]          an_n,
    output logic [IDX_W-1:0]           digit_idx,
    output logic                       frame_done
);

    localparam int VAL_W = NIBBLE_W * DIGITS;
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0]  CNT_BLANK_END = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_PRE_LAST  = CNT_W'(REFRESH_DIV - 2);
    localparam logic [IDX_W-1:0]  IDX_MAX       = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_DARK       = AN_OFF[DIGITS-1:0];

    // -------------------------------------------------------------------------
    // Slot timebase
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic             slot_wrap;
    logic             frame_end;

    seg7_scan_timer #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt       (cnt),
        .digit_idx (digit_idx),
        .slot_wrap (slot_wrap),
        .frame_end (frame_end)
    );

    // -------------------------------------------------------------------------
    // Capture / transfer
    // -------------------------------------------------------------------------
    logic [VAL_W-1:0] shadow;
    logic [VAL_W-1:0] active;
    logic [VAL_W-1:0] active_d;
    logic             pending;

    // NOTE: every combinational output gets a default before any conditional
    // assignment; a path that leaves it unassigned would infer a latch.
    always_comb begin
        active_d = active;
        if (frame_end) begin
            // A load on the boundary cycle itself bypasses the shadow, so it
            // is not deferred by a whole frame.
            if (load) begin
                active_d = value_in;
            end else if (pending) begin
                active_d = shadow;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-slot digit code
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0]    idx_next;
    logic [NIBBLE_W-1:0] nibble_d;

    always_comb begin
        idx_next = digit_idx;
        if (slot_wrap) begin
            idx_next = (digit_idx == IDX_MAX) ? '0 : digit_idx + 1'b1;
        end
        // Read from active_d so slot 0 of a new frame already sees the value
        // transferred on the boundary edge.
        nibble_d = active_d[NIBBLE_W*idx_next +: NIBBLE_W];
    end

    // -------------------------------------------------------------------------
    // Anode pattern for the DRIVE window of the current slot
    // -------------------------------------------------------------------------
    logic [DIGITS-1:0] sel;
    logic [DIGITS-1:0] show;
    logic [DIGITS-1:0] drive_an;

    always_comb begin
        sel            = '0;
        sel[digit_idx] = 1'b1;
    end

`ifdef SEG7_SCAN_LZB_EN
    // show[k] is set when digit k or any digit above it is non-zero. Derived
    // from active only, so the mask is constant for a whole frame.
    logic lzb_seen;

    always_comb begin
        lzb_seen = 1'b0;
        show     = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lzb_seen = lzb_seen | (active[NIBBLE_W*k +: NIBBLE_W] != '0);
            show[k]  = lzb_seen;
        end
        // Digit 0 is always lit so a zero value reads as a single "0".
        show[0] = 1'b1;
    end
`else
    assign show = '1;
`endif

    assign drive_an = ~(sel & show);

    // -------------------------------------------------------------------------
    // Registers: capture, transfer, blanking FSM and outputs
    // -------------------------------------------------------------------------
    scan_state_t state;

    // NOTE: shadow and active are ordinary flops rather than a memory array,
    // so they take the async reset like everything else and a reset display
    // always restarts from an all-zero value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            state      <= BLANK;
            an_n       <= AN_DARK;
            nibble     <= '0;
            frame_done <= 1'b0;
        end else begin
            active <= active_d;

            // Back-to-back loads simply overwrite; the last one wins.
            if (load) begin
                shadow <= value_in;
            end

            // The boundary consumes any pending value (or the bypassed load).
            if (frame_end) begin
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end

            // Registered one cycle early so the pulse lands on the boundary.
            frame_done <= (cnt == CNT_PRE_LAST) && (digit_idx == IDX_MAX);

            if (slot_wrap) begin
                // New slot: go dark and present the next digit's code while
                // blanked, so the decoder settles before the anode turns on.
                state  <= BLANK;
                an_n   <= AN_DARK;
                nibble <= nibble_d;
            end else if ((state == BLANK) && (cnt == CNT_BLANK_END)) begin
                state <= DRIVE;
                an_n  <= drive_an;
            end
        end
    end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Multiplexed display scanner for an N-digit common-anode 7-segment display. Captures a packed hex value, time-multiplexes one digit at a time with an inter-digit blanking gap to suppress ghosting, and drives the 4-bit digit code to the team's active-low 7-segment decoder together with the active-low anode enables. Displayed values change only at frame boundaries, so the display never tears.

## Interface
- `DIGITS`, default 4: number of digits; legal range 1..8.
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYCLES`, default 16: cycles at slot start with all anodes off; must satisfy 1 ≤ BLANK_CYCLES < REFRESH_DIV.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `value_in` in 4*DIGITS: packed value; digit k is `value_in[4k+3:4k]`; digit 0 is least significant.
- `load` in 1: one-cycle strobe that captures `value_in`.
- `nibble` out 4: code of the current digit, sent to the decoder input.
- `an_n` out DIGITS: active-low anode enables; at most one bit is low at any time.
- `digit_idx` out $clog2(DIGITS) (min 1): index of the current slot.
- `frame_done` out 1: one-cycle pulse on the last cycle of each frame.

## Operation
- Registers: `shadow` (4*DIGITS), `active` (4*DIGITS), `pending`, slot counter `cnt` (width $clog2(REFRESH_DIV)), `digit_idx`, and state {BLANK, DRIVE}.
- `load` = 1: `shadow <= value_in`, `pending <= 1`. Back-to-back loads: the last load wins.
- Frame boundary is the cycle where `cnt == REFRESH_DIV-1` and `digit_idx == DIGITS-1`.
  - At the boundary, if `pending` is set: `active <= shadow`, `pending <= 0`.
  - If `load` arrives on the boundary cycle: `active <= value_in` directly (bypass) and `pending <= 0`.
- `cnt` counts 0..REFRESH_DIV-1 and wraps. On wrap, `digit_idx` increments and wraps from DIGITS-1 to 0.
- State BLANK holds while `cnt < BLANK_CYCLES`; `an_n` is all ones.
- State DRIVE covers `cnt` from BLANK_CYCLES to REFRESH_DIV-1; `an_n[digit_idx] = 0` and all other bits are 1.
- `nibble` is `active[4*digit_idx +: 4]`, registered. It updates on the first cycle of each slot, while the display is blanked.
- `frame_done` is high on the boundary cycle only.
- Reset values (asynchronous): `an_n` all ones, `nibble` 0, `digit_idx` 0, `cnt` 0, `frame_done` 0, `shadow` 0, `active` 0, `pending` 0, state BLANK.
- Reset mid-DRIVE: `an_n` goes to all ones immediately, without waiting for a clock edge.

## Timing
- First edge after reset release is cycle 0. Digit 0 is blanked for cycles 0..BLANK_CYCLES-1 and driven for cycles BLANK_CYCLES..REFRESH_DIV-1.
- Frame length is DIGITS*REFRESH_DIV cycles.
- A load is displayed within at most one full frame plus one cycle of `load`.
- All outputs are registered, with no combinational path from input to output.
- DIGITS=1: `digit_idx` is held at 0 and every slot is a frame.

## Configuration
- `SEG7_SCAN_LZB_EN` defined: leading-zero blanking.
  - Any digit above the highest non-zero digit of `active` keeps its `an_n` bit high during DRIVE.
  - Digit 0 is always displayed, so an `active` of 0 shows a single "0".
  - The zero-detect is computed from `active` only, so it changes only at frame boundaries.
- Macro undefined: every digit is driven in its DRIVE window, and no zero-detect logic is present.

## Structure
- Package `seg7_pkg` holds:
  - `NIBBLE_W = 4`
  - `AN_OFF` (all-ones anode constant)
  - `scan_state_t` enum {BLANK, DRIVE}
  - the default values of DIGITS, REFRESH_DIV and BLANK_CYCLES
- Sub-module `seg7_scan_timer` contains the slot counter plus digit index. Its outputs are `cnt`, `digit_idx`, a slot-wrap strobe and a frame-boundary strobe. The top level holds the capture/transfer logic, the blanking FSM and the anode drive.

## Test plan
All tests use DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset: hold `rst_n` = 0, giving `an_n` = 1111, `nibble` = 0, `frame_done` = 0. After release, cycles 0–1 give `an_n` = 1111 and cycles 2–7 give `an_n` = 1110. `frame_done` pulses at cycle 31, and it pulses again at cycle 63.
- Load 0x1234 at cycle 5. Frame 0 shows 0000. In frame 1, slot 0 gives `nibble` = 4 with `an_n` = 1110, and slot 3 gives `nibble` = 1 with `an_n` = 0111.
- With `active` = 0x1234, load 0xABCD during slot 2. Slots 2–3 of the current frame still show 2 and 1. The next frame shows D, C, B, A.
- Load 0x5555 exactly on the boundary cycle (cycle 31): the frame starting at cycle 32 shows 5 in all digits. Loads of 0x1111 then 0x2222 on consecutive cycles result in 0x2222 being displayed.
- Assert `rst_n` low at cycle 12 (digit 1 in DRIVE). `an_n` = 1111 before the next edge, and the scan restarts at digit 0 with `active` = 0.
- With `SEG7_SCAN_LZB_EN`: 0x0050 keeps `an_n[3:2]` high and drives digit 1 = 5 and digit 0 = 0. The value 0x0000 drives digit 0 only.
